// File: rtl/fpu_pkg.sv
// Shared constants and types for the FPU adder datapath.
package fpu_pkg;

  localparam int MANT_RAW_W = 28;
  localparam int EXP_W      = 8;
  localparam int FRAC_W     = 23;
  localparam int IEXP_W     = 10;  // signed internal exponent, wide enough for adjust

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  // Bit positions inside the raw mantissa
  localparam int CARRY_BIT  = 27;
  localparam int HIDDEN_BIT = 26;
  localparam int G_BIT      = 2;
  localparam int R_BIT      = 1;
  localparam int S_BIT      = 0;

  // Normalized value held between the normalize and round stages
  typedef struct packed {
    logic              sign;
    logic              zero;
    logic              uf;
    logic [IEXP_W-1:0] exp;   // two's complement
    logic [26:0]       mant;  // bit26 hidden, 25:3 fraction, 2:0 G/R/S
  } norm_t;

endpackage

// File: rtl/normalize_round_lzc28.sv
// Leading-zero counter over a 27-bit mantissa field.
module lzc28 (
  input  logic [26:0] i_value,
  output logic [4:0]  o_count,
  output logic        o_zero
);

  // Scan upward so the highest set bit determines the final count
  always_comb begin
    o_count = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (i_value[i]) o_count = 5'(26 - i);
    end
    o_zero = ~|i_value;
  end

endmodule

// File: rtl/normalize_round.sv
// Two-stage normalize + round-to-nearest-even for the FPU adder.
module normalize_round
  import fpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [MANT_RAW_W-1:0] mantisa_raw,
  input  logic                  sign_result,
  input  logic [EXP_W-1:0]      exp_in,
  output logic                  valid_out,
  output logic [31:0]           result,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  inexact
);

  logic [4:0]        w_lz;
  logic              w_lz_zero;
  logic [IEXP_W-1:0] w_exp_base;
  norm_t             w_norm;

  logic              r_v1;
  norm_t             r_s1;

  logic [FRAC_W-1:0] w_frac;
  logic              w_g, w_r, w_s;
  logic              w_rnd_up;
  logic [24:0]       w_sum;
  logic [IEXP_W-1:0] w_exp2;
  logic [31:0]       w_res;
  logic              w_ov, w_uf, w_ix;

  lzc28 u_lzc (
    .i_value (mantisa_raw[26:0]),
    .o_count (w_lz),
    .o_zero  (w_lz_zero)
  );

  assign w_exp_base = {2'b00, exp_in};

  // Stage 1 next value: normalize so the hidden bit lands at bit 26
  always_comb begin
    w_norm      = '0;
    w_norm.sign = sign_result;
    if (mantisa_raw[CARRY_BIT]) begin
      // Fold the two dropped bits into sticky
      w_norm.mant = {mantisa_raw[27:2], mantisa_raw[R_BIT] | mantisa_raw[S_BIT]};
      w_norm.exp  = w_exp_base + 10'd1;
    end else if (w_lz_zero) begin
      w_norm.zero = 1'b1;
      w_norm.sign = 1'b0;
    end else begin
      w_norm.mant = mantisa_raw[26:0] << w_lz;
      w_norm.exp  = w_exp_base - {5'b0, w_lz};
    end
    w_norm.uf = ~w_norm.zero && ($signed(w_norm.exp) <= 10'sd0);
  end

  // Stage 1 register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1 <= 1'b0;
      r_s1 <= '0;
    end else begin
      r_v1 <= valid_in;
      if (valid_in) r_s1 <= w_norm;
    end
  end

  // Stage 2 next value: round to nearest even, renormalize on carry, classify
  always_comb begin
    w_frac   = r_s1.mant[25:3];
    w_g      = r_s1.mant[G_BIT];
    w_r      = r_s1.mant[R_BIT];
    w_s      = r_s1.mant[S_BIT];
    w_rnd_up = w_g & (w_r | w_s | w_frac[0]);
    w_sum    = {1'b0, r_s1.mant[HIDDEN_BIT], w_frac} + {24'b0, w_rnd_up};
    w_exp2   = r_s1.exp + {9'b0, w_sum[24]};
    w_res    = '0;
    w_ov     = 1'b0;
    w_uf     = 1'b0;
    w_ix     = 1'b0;
    if (r_s1.zero) begin
      w_res = '0;
    end else if (r_s1.uf) begin
      w_res = {r_s1.sign, 31'b0};
      w_uf  = 1'b1;
      w_ix  = 1'b1;
    end else if ($signed(w_exp2) >= 10'sd255) begin
      w_res = {r_s1.sign, EXP_MAX, {FRAC_W{1'b0}}};
      w_ov  = 1'b1;
      w_ix  = 1'b1;
    end else begin
      // On carry-out the fraction is all zero anyway; select it explicitly
      w_res = {r_s1.sign, w_exp2[EXP_W-1:0], w_sum[24] ? {FRAC_W{1'b0}} : w_sum[22:0]};
      w_ix  = w_g | w_r | w_s;
    end
  end

  // Output register; data holds while no valid result arrives
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      inexact   <= 1'b0;
    end else begin
      valid_out <= r_v1;
      if (r_v1) begin
        result    <= w_res;
        overflow  <= w_ov;
        underflow <= w_uf;
        inexact   <= w_ix;
      end
    end
  end

endmodule

// File: tb/tb_normalize_round.sv
// Bench for normalize_round: directed table, streaming/reset sequences, random vs model.
module tb_normalize_round;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [27:0] mantisa_raw;
  logic        sign_result;
  logic [7:0]  exp_in;
  logic        valid_out;
  logic [31:0] result;
  logic        overflow, underflow, inexact;

  int n_vec = 0;
  int n_err = 0;

  normalize_round dut (
    .clk         (clk),
    .rst         (rst),
    .valid_in    (valid_in),
    .mantisa_raw (mantisa_raw),
    .sign_result (sign_result),
    .exp_in      (exp_in),
    .valid_out   (valid_out),
    .result      (result),
    .overflow    (overflow),
    .underflow   (underflow),
    .inexact     (inexact)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic        ov;
    logic        uf;
    logic        ix;
  } out_t;

  typedef struct {
    logic [27:0] mant;
    logic [7:0]  e;
    logic        s;
    out_t        o;
  } vec_t;

  typedef struct {
    out_t o;
    int   cyc;
  } pend_t;

  vec_t  tbl[14];
  pend_t q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  function automatic out_t dut_out();
    return '{res: result, ov: overflow, uf: underflow, ix: inexact};
  endfunction

  // Reference: value = raw * 2^(exp_in - 127 - 26); keep 24 significant bits, RNE on the rest
  function automatic out_t model(logic [27:0] raw, logic [7:0] e_in, logic s);
    out_t   o;
    longint r, kept, rem, half;
    int     p, sh, e;
    o = '0;
    r = longint'(raw);
    if (r == 0) return o;
    p = 27;
    while (r[p] == 1'b0) p--;
    e = int'(e_in) + p - 26;
    if (e <= 0) begin
      o.res = {s, 31'b0};
      o.uf  = 1'b1;
      o.ix  = 1'b1;
      return o;
    end
    if (p > 23) begin
      sh   = p - 23;
      kept = r >> sh;
      rem  = r & ((64'd1 << sh) - 1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && kept[0])) kept = kept + 1;
    end else begin
      kept = r << (23 - p);
      rem  = 0;
    end
    if (kept == (64'd1 << 24)) begin
      kept = kept >> 1;
      e    = e + 1;
    end
    if (e >= 255) begin
      o.res = {s, 8'hFF, 23'b0};
      o.ov  = 1'b1;
      o.ix  = 1'b1;
    end else begin
      o.res = {s, 8'(e), kept[22:0]};
      o.ix  = (rem != 0);
    end
    return o;
  endfunction

  task automatic drive(input logic v, input logic [27:0] m, input logic [7:0] e, input logic s);
    valid_in    = v;
    mantisa_raw = m;
    exp_in      = e;
    sign_result = s;
  endtask

  initial begin
    //           mant          exp     s      result         ov    uf    ix
    tbl[0]  = '{28'h8000000, 8'd127, 1'b0, '{32'h40000000, 1'b0, 1'b0, 1'b0}};
    tbl[1]  = '{28'h0000008, 8'd127, 1'b0, '{32'h34000000, 1'b0, 1'b0, 1'b0}};
    tbl[2]  = '{28'h400000C, 8'd127, 1'b0, '{32'h3F800002, 1'b0, 1'b0, 1'b1}};
    tbl[3]  = '{28'h4000004, 8'd127, 1'b0, '{32'h3F800000, 1'b0, 1'b0, 1'b1}};
    tbl[4]  = '{28'h7FFFFFC, 8'd127, 1'b0, '{32'h40000000, 1'b0, 1'b0, 1'b1}};
    tbl[5]  = '{28'hFFFFFFF, 8'd254, 1'b0, '{32'h7F800000, 1'b1, 1'b0, 1'b1}};
    tbl[6]  = '{28'h0000000, 8'd127, 1'b1, '{32'h00000000, 1'b0, 1'b0, 1'b0}};
    tbl[7]  = '{28'h4000000, 8'd0,   1'b1, '{32'h80000000, 1'b0, 1'b1, 1'b1}};
    tbl[8]  = '{28'h4000000, 8'd1,   1'b0, '{32'h00800000, 1'b0, 1'b0, 1'b0}};
    tbl[9]  = '{28'h7FFFFFC, 8'd254, 1'b1, '{32'hFF800000, 1'b1, 1'b0, 1'b1}};
    tbl[10] = '{28'h000000C, 8'd127, 1'b1, '{32'hB4400000, 1'b0, 1'b0, 1'b0}};
    tbl[11] = '{28'h8000003, 8'd100, 1'b0, '{32'h32800000, 1'b0, 1'b0, 1'b1}};
    tbl[12] = '{28'h800000C, 8'd127, 1'b0, '{32'h40000001, 1'b0, 1'b0, 1'b1}};
    tbl[13] = '{28'h0000001, 8'd26,  1'b0, '{32'h00000000, 1'b0, 1'b1, 1'b1}};

    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    repeat (2) @(negedge clk);
    check("reset_valid", 64'(valid_out), 64'd0);
    check("reset_outs", 64'(dut_out()), 64'd0);
    rst = 1'b0;

    // Directed table, one isolated transaction each with latency check
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(1'b1, tbl[i].mant, tbl[i].e, tbl[i].s);
      @(negedge clk);
      drive(1'b0, '0, '0, 1'b0);
      check($sformatf("tbl%0d_early", i), 64'(valid_out), 64'd0);
      @(negedge clk);
      check($sformatf("tbl%0d_valid", i), 64'(valid_out), 64'd1);
      check($sformatf("tbl%0d_out", i), 64'(dut_out()), 64'(tbl[i].o));
    end

    // Five back-to-back inputs come out on five consecutive cycles, in order
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        check($sformatf("stream%0d_valid", i - 2), 64'(valid_out), 64'd1);
        check($sformatf("stream%0d_out", i - 2), 64'(dut_out()), 64'(tbl[i - 2].o));
      end
      if (i < 5) drive(1'b1, tbl[i].mant, tbl[i].e, tbl[i].s);
      else drive(1'b0, '0, '0, 1'b0);
    end
    @(negedge clk);
    check("stream_done", 64'(valid_out), 64'd0);

    // Reset mid-stream clears outputs at once and drops in-flight data
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, tbl[5 + 4 * (i % 2)].mant, tbl[5 + 4 * (i % 2)].e, tbl[5 + 4 * (i % 2)].s);
    end
    @(negedge clk);
    check("pre_rst_valid", 64'(valid_out), 64'd1);
    check("pre_rst_out", 64'(dut_out()), 64'(tbl[9].o));
    rst = 1'b1;
    #1;
    check("rst_valid", 64'(valid_out), 64'd0);
    check("rst_outs", 64'(dut_out()), 64'd0);
    drive(1'b0, '0, '0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("post_rst%0d_valid", i), 64'(valid_out), 64'd0);
    end

    // Random traffic against the model, with gaps
    for (int c = 0; c < 3003; c++) begin
      logic [27:0] m;
      logic [7:0]  e;
      logic        s, v;
      pend_t       p;
      @(negedge clk);
      if (valid_out) begin
        if (q.size() == 0) begin
          check("rand_spurious_valid", 64'd1, 64'd0);
        end else begin
          p = q.pop_front();
          check($sformatf("rand_c%0d_latency", c), 64'(c - p.cyc), 64'd2);
          check($sformatf("rand_c%0d_out", c), 64'(dut_out()), 64'(p.o));
        end
      end else if (q.size() != 0 && c - q[0].cyc >= 2) begin
        check("rand_missing_valid", 64'd0, 64'd1);
        void'(q.pop_front());
      end
      v = (c < 3000) && ($urandom_range(0, 3) != 0);
      s = 1'($urandom());
      e = 8'($urandom());
      case ($urandom_range(0, 3))
        0: m = 28'($urandom());
        1: m = {2'b01, 26'($urandom())};
        2: m = 28'($urandom()) >> $urandom_range(1, 27);
        default: m = {1'b0, 1'($urandom()), {23{1'b1}}, 3'($urandom())};
      endcase
      if ($urandom_range(0, 49) == 0) m = '0;
      drive(v, m, e, s);
      if (v) q.push_back('{o: model(m, e, s), cyc: c});
    end
    check("rand_drained", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/normalize_round.md
# normalize_round

Post-add/subtract normalization and rounding stage of the FPU adder datapath. Consumes the registered 28-bit raw mantissa and result sign from the mantissa add/subtract stage, together with the aligned (larger) biased exponent. Produces a packed IEEE-754 single-precision result after a 2-stage pipeline: normalize, then round-to-nearest-even. Flags overflow, underflow and inexact; denormal results flush to zero.

## Interface
- No parameters; widths are fixed by the package constants.
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- valid_in  in  1  mantisa_raw/sign_result/exp_in valid this cycle
- mantisa_raw  in  28  bit27 carry, bit26 hidden, bits25:3 fraction, bit2 G, bit1 R, bit0 S
- sign_result  in  1  sign of raw result
- exp_in  in  8  biased exponent of the aligned operands
- valid_out  out  1  result and flags valid
- result  out  32  {sign, exp[7:0], frac[22:0]}
- overflow  out  1  result rounded to ±Inf
- underflow  out  1  nonzero result flushed to ±0
- inexact  out  1  any of G/R/S nonzero after normalization

## Operation
- Internal exponent: 10-bit signed, avoids wrap during adjust.
- Stage 1 (normalize), registered:
  - mantisa_raw[27]=1: shift right 1, new bit0 = old bit1 | old bit0 (sticky kept), exp = exp_in+1.
  - mantisa_raw==0: zero flag set, exp=0, sign forced 0 (+0).
  - Otherwise lz = leading zeros of mantisa_raw[26:0] (0..26); shift left lz, exp = exp_in−lz.
  - exp ≤ 0 after adjust on nonzero value: underflow flag set.
- Stage 2 (round), registered:
  - frac=m[25:3], G=m[2], R=m[1], S=m[0]; inexact = G|R|S.
  - Round up when G & (R | S | frac[0]).
  - {1,frac}+1 carries out: frac=0, exp+1.
  - exp ≥ 255: result {sign, 8'hFF, 23'b0}, overflow=1, inexact=1.
  - Underflow: result {sign, 31'b0}, underflow=1, inexact=1.
  - Zero: result 32'h00000000, all flags 0.
- Priority: zero > underflow > overflow > normal.
- No backpressure; a new input is accepted every cycle.

## Timing
- Latency: 2 cycles, valid_in at edge N → valid_out at edge N+2; throughput 1/cycle.
- Flags and result are qualified by valid_out; they hold last values when valid_out=0.
- Reset: valid pipeline, result, overflow, underflow, inexact all 0 asynchronously; in-flight data discarded, no valid_out after reset deasserts until new valid_in.
- Back-to-back inputs must not interfere; each stage register is fully independent.
- Round-carry renormalization completes in stage 2; no extra cycle.

## Structure
- Shared package fpu_pkg: MANT_RAW_W=28, EXP_W=8, FRAC_W=23, EXP_MAX=8'hFF, bit-position constants for carry/hidden/G/R/S.
- Sub-module lzc28: combinational leading-zero counter over 27 bits, 5-bit output, all-zero flag.
- Top holds the two pipeline stages and flag logic.

## Test plan
- 1.0+1.0: mantisa_raw=28'h8000000, exp_in=127, sign 0 → result 32'h40000000, flags 0, valid_out 2 cycles later.
- Massive cancellation: mantisa_raw=28'h0000008, exp_in=127 → lz=23, result 32'h34000000.
- RNE tie: 28'h400000C, exp_in=127 → 32'h3F800002, inexact=1; 28'h4000004 → 32'h3F800000, inexact=1.
- Round carry: 28'h7FFFFFC, exp_in=127 → 32'h40000000, inexact=1.
- Overflow: 28'hFFFFFFF, exp_in=254, sign 0 → 32'h7F800000, overflow=1; zero: 28'h0, sign 1 → 32'h00000000, no flags.
- Streaming + reset: 5 back-to-back inputs produce 5 consecutive valid_out in order; rst asserted mid-stream clears valid_out and all outputs to 0 immediately.
